parallel_to_serial_dbuf: RTL

PARALLEL_TO_SERIAL_DBUF -- requirements
Module: parallel_to_serial_dbuf

---
 rtl/parallel_to_serial_dbuf.sv | 73 +++++++
 1 files changed

// File: rtl/parallel_to_serial_dbuf.sv
// Word-to-bitstream serializer with a one-word holding register for gapless output.
// Define PARALLEL_TO_SERIAL_MSB_FIRST_EN to emit bits MSB first (default LSB first).
module parallel_to_serial_dbuf #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             parallel_valid,
    output logic             parallel_ready,
    input  logic [width-1:0] parallel_data,
    output logic             serial_valid,
    input  logic             serial_ready,
    output logic             serial_data,
    output logic             busy
);

    localparam int CW = $clog2(width + 1);
    localparam logic [CW-1:0] FULL = CW'(width);

    logic [width-1:0] sh;
    logic [width-1:0] hold;
    logic [width-1:0] shifted;
    logic [CW-1:0]    cnt;
    logic             hold_full;
    logic             xfer;
    logic             last;
    logic             accept;
    logic             direct;

    assign parallel_ready = !hold_full;
    assign serial_valid   = (cnt != '0);
    assign busy           = serial_valid || hold_full;

    assign xfer   = serial_valid && serial_ready;
    assign last   = xfer && (cnt == CW'(1));
    assign accept = parallel_valid && parallel_ready;
    // Shifter is free now or frees on this edge with nothing waiting in hold.
    assign direct = (cnt == '0) || last;

`ifdef PARALLEL_TO_SERIAL_MSB_FIRST_EN
    assign serial_data = sh[width-1];
    assign shifted     = {sh[width-2:0], 1'b0};
`else
    assign serial_data = sh[0];
    assign shifted     = {1'b0, sh[width-1:1]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh        <= '0;
            hold      <= '0;
            cnt       <= '0;
            hold_full <= 1'b0;
        end else begin
            if (last && hold_full) begin
                sh        <= hold;
                cnt       <= FULL;
                hold_full <= 1'b0;
            end else if (accept && direct) begin
                sh  <= parallel_data;
                cnt <= FULL;
            end else if (xfer) begin
                sh  <= shifted;
                cnt <= cnt - CW'(1);
            end
            if (accept && !direct) begin
                hold      <= parallel_data;
                hold_full <= 1'b1;
            end
        end
    end

endmodule
